// File: rtl/cpu_sequencer.sv
// Multi-cycle phase sequencer: one-hot phase strobes, memory start/busy handshake,
// and between-instruction interrupt take (interrupt logic built only with CPU_SEQ_INT_EN).
module cpu_sequencer #(
  parameter int NUM_INT      = 4,
  parameter int INT_ID_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              instr_op,
  input  logic                    busy,
  output logic                    start,
  output logic                    fetch,
  output logic                    get_regs,
  output logic                    read_mem,
  output logic                    write_back,
  input  logic [NUM_INT-1:0]      int_req,
  output logic                    int_take,
  output logic [INT_ID_WIDTH-1:0] int_id,
  output logic                    in_isr
);

  localparam logic [3:0] OP_RETI  = 4'b0001;
  localparam logic [3:0] OP_COPY  = 4'b1100;
  localparam logic [3:0] OP_WRITE = 4'b1101;
  localparam logic [3:0] OP_READ  = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_INT
  } state_t;

  state_t     state, state_next;
  logic [1:0] cnt;
  logic       mem_phase;
  logic       phase_done;
  logic       take_int;

  always_comb begin
    mem_phase = 1'b0;
    case (state)
      S_FETCH: mem_phase = 1'b1;
      S_MEM:   mem_phase = (instr_op == OP_READ) || (instr_op == OP_WRITE) || (instr_op == OP_COPY);
      S_WB:    mem_phase = (instr_op == OP_WRITE) || (instr_op == OP_COPY);
      default: mem_phase = 1'b0;
    endcase
  end

  // cnt: 0 = start cycle, 1 = mandatory wait cycle, 2 = watching busy for completion
  assign phase_done = !mem_phase || ((cnt == 2'd2) && !busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 2'd0;
    else if (state_next != state)
      cnt <= 2'd0;
    else if (cnt != 2'd2)
      cnt <= cnt + 2'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (phase_done) state_next = S_DECODE;
      S_DECODE: state_next = S_MEM;
      S_MEM:    if (phase_done) state_next = S_WB;
      S_WB:     if (phase_done) state_next = take_int ? S_INT : S_FETCH;
      S_INT:    state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start      = mem_phase && (cnt == 2'd0);
    fetch      = (state == S_FETCH);
    get_regs   = (state == S_DECODE);
    read_mem   = (state == S_MEM);
    write_back = (state == S_WB);
  end

`ifdef CPU_SEQ_INT_EN
  logic [NUM_INT-1:0]      pending;
  logic [NUM_INT-1:0]      req_d;
  logic [NUM_INT-1:0]      pend_clr;
  logic [INT_ID_WIDTH-1:0] low_id;
  logic [INT_ID_WIDTH-1:0] id_reg;
  logic                    isr_reg;
  logic                    isr_after;

  always_comb begin
    low_id = '0;
    for (int i = NUM_INT - 1; i >= 0; i--)
      if (pending[i]) low_id = INT_ID_WIDTH'(i);
  end

  // RETI in this WB is applied before deciding whether to take
  assign isr_after = isr_reg && !((state == S_WB) && (instr_op == OP_RETI));
  assign take_int  = (pending != '0) && !isr_after;
  assign pend_clr  = (state == S_INT) ? (NUM_INT'(1) << id_reg) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      req_d   <= '0;
      isr_reg <= 1'b0;
      id_reg  <= '0;
    end else begin
      req_d   <= int_req;
      pending <= (pending & ~pend_clr) | (int_req & ~req_d);
      if ((state == S_WB) && phase_done) begin
        isr_reg <= take_int ? 1'b1 : isr_after;
        if (take_int) id_reg <= low_id;
      end
    end
  end

  assign int_take = (state == S_INT);
  assign int_id   = id_reg;
  assign in_isr   = isr_reg;
`else
  logic unused_int_req;
  assign unused_int_req = ^int_req;
  assign take_int = 1'b0;
  assign int_take = 1'b0;
  assign int_id   = '0;
  assign in_isr   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a latency-programmable memory responder;
// interrupt scenarios run when CPU_SEQ_INT_EN is defined.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] instr_op;
  logic       busy;
  logic       start, fetch, get_regs, read_mem, write_back;
  logic [3:0] int_req;
  logic       int_take;
  logic [7:0] int_id;
  logic       in_isr;

  logic [3:0] lat;
  logic [3:0] bcnt;
  logic       force_busy;
  logic [5:0] outs;

  int n_vec;
  int n_bad;

  cpu_sequencer #(.NUM_INT(4), .INT_ID_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (rst),
    .instr_op   (instr_op),
    .busy       (busy),
    .start      (start),
    .fetch      (fetch),
    .get_regs   (get_regs),
    .read_mem   (read_mem),
    .write_back (write_back),
    .int_req    (int_req),
    .int_take   (int_take),
    .int_id     (int_id),
    .in_isr     (in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: busy high for lat cycles starting the cycle after start
  always @(posedge clk or posedge rst) begin
    if (rst)
      bcnt <= 4'd0;
    else if (start)
      bcnt <= lat;
    else if (bcnt != 4'd0)
      bcnt <= bcnt - 4'd1;
  end
  assign busy = (bcnt != 4'd0) || force_busy;

  assign outs = {start, fetch, get_regs, read_mem, write_back, int_take};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts at the sample point of the instruction's first FETCH cycle; phase
  // lengths fl/ml/wl are hand-computed by the caller (DECODE is always 1).
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] l,
                           input int fl, input int ml, input int wl, output int starts);
    int         len;
    logic [3:0] ph;
    logic [5:0] exp;
    instr_op = op;
    lat      = l;
    starts   = 0;
    for (int p = 0; p < 4; p++) begin
      len = (p == 0) ? fl : (p == 1) ? 1 : (p == 2) ? ml : wl;
      ph  = 4'b1000 >> p;
      for (int k = 0; k < len; k++) begin
        exp = {((k == 0) && (len > 1)), ph, 1'b0};
        chk(tag, 32'(outs), 32'(exp));
        if (start) starts++;
        step();
      end
    end
    $display("instr %s op=%b L=%0d starts=%0d", tag, op, l, starts);
  endtask

  int s;

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    instr_op   = 4'b0010;
    int_req    = 4'b0000;
    force_busy = 1'b0;
    lat        = 4'd1;
    step();
    step();
    chk("reset_outs", 32'(outs), 32'(6'b000000));
    chk("reset_in_isr", 32'(in_isr), 32'(1'b0));
    chk("reset_int_id", 32'(int_id), 32'(8'd0));

    // Release: one IDLE cycle, then FETCH with start
    rst = 1'b0;
    chk("idle_after_reset", 32'(outs), 32'(6'b000000));
    step();
    run_instr("arith_L1", 4'b0010, 4'd1, 3, 1, 1, s);
    chk("arith_starts", 32'(s), 32'(1));
    run_instr("arith_L1_b", 4'b0011, 4'd1, 3, 1, 1, s);
    run_instr("copy_L3", 4'b1100, 4'd3, 5, 5, 5, s);
    chk("copy_starts", 32'(s), 32'(3));
    run_instr("read_L2", 4'b1110, 4'd2, 4, 4, 1, s);
    chk("read_starts", 32'(s), 32'(2));
    run_instr("write_L1", 4'b1101, 4'd1, 3, 3, 3, s);
    chk("write_starts", 32'(s), 32'(3));
    run_instr("push_L2", 4'b0100, 4'd2, 4, 1, 1, s);
    run_instr("halt_L1", 4'b1111, 4'd1, 3, 1, 1, s);

`ifndef CPU_SEQ_INT_EN
    // Interrupt lines are ignored: timing stays that of a plain ARITH
    int_req = 4'b0110;
    run_instr("arith_int_ignored", 4'b0010, 4'd1, 3, 1, 1, s);
    int_req = 4'b0000;
    run_instr("arith_int_ignored_b", 4'b0010, 4'd1, 3, 1, 1, s);
    int_req = 4'b1011;
    run_instr("reti_no_isr", 4'b0001, 4'd1, 3, 1, 1, s);
    chk("noint_in_isr", 32'(in_isr), 32'(1'b0));
    chk("noint_int_id", 32'(int_id), 32'(8'd0));
`endif

    // Reset in the middle of a READ's MEM phase with busy held high
    instr_op = 4'b1110;
    lat      = 4'd3;
    for (int i = 0; i < 20 && !read_mem; i++) step();
    chk("read_mem_reached", 32'(read_mem), 32'(1'b1));
    step();
    step();
    chk("read_mem_stalled", 32'(outs), 32'(6'b000100));
    force_busy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs), 32'(6'b000000));
    chk("async_reset_in_isr", 32'(in_isr), 32'(1'b0));
    step();
    step();
    rst = 1'b0;
    chk("idle_after_abort", 32'(outs), 32'(6'b000000));
    step();
    instr_op = 4'b0010;
    chk("refetch_start", 32'(outs), 32'(6'b110000));
    step();
    for (int i = 0; i < 4; i++) begin
      chk("refetch_wait_no_restart", 32'(outs), 32'(6'b010000));
      step();
    end
    force_busy = 1'b0;
    chk("refetch_complete", 32'(outs), 32'(6'b010000));
    step();
    chk("after_abort_decode", 32'(outs), 32'(6'b001000));
    step();
    chk("after_abort_mem", 32'(outs), 32'(6'b000100));
    step();
    chk("after_abort_wb", 32'(outs), 32'(6'b000010));
    step();

`ifdef CPU_SEQ_INT_EN
    // Two lines rise during an ARITH: lowest index taken first
    int_req = 4'b0110;
    run_instr("int_arith", 4'b0010, 4'd1, 3, 1, 1, s);
    chk("take1", 32'(outs), 32'(6'b000001));
    step();
    chk("take1_id", 32'(int_id), 32'(8'd1));
    chk("take1_in_isr", 32'(in_isr), 32'(1'b1));
    run_instr("isr_body", 4'b0010, 4'd1, 3, 1, 1, s);
    run_instr("reti1", 4'b0001, 4'd1, 3, 1, 1, s);
    chk("take2", 32'(outs), 32'(6'b000001));
    step();
    chk("take2_id", 32'(int_id), 32'(8'd2));
    chk("take2_in_isr", 32'(in_isr), 32'(1'b1));

    // Bit 0 rises inside the ISR, then again in the INT cycle that clears it
    int_req = 4'b0111;
    run_instr("isr_body2", 4'b0010, 4'd1, 3, 1, 1, s);
    int_req = 4'b0110;
    run_instr("reti2", 4'b0001, 4'd1, 3, 1, 1, s);
    chk("take3", 32'(outs), 32'(6'b000001));
    int_req = 4'b0111;
    step();
    chk("take3_id", 32'(int_id), 32'(8'd0));
    run_instr("isr_body3", 4'b0010, 4'd1, 3, 1, 1, s);
    run_instr("reti3", 4'b0001, 4'd1, 3, 1, 1, s);
    chk("take4_set_wins", 32'(outs), 32'(6'b000001));
    step();
    chk("take4_id", 32'(int_id), 32'(8'd0));
    chk("take4_in_isr", 32'(in_isr), 32'(1'b1));
    chk("after_take4_fetch", 32'(outs), 32'(6'b110000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
